// File: rtl/nanov_sequencer.sv
// Instruction fetch and bit-serial sequencer for the nanoV core; owns the PC.
// Optional one-word prefetch buffer enabled by defining NANOV_PREFETCH_EN.
module nanov_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  input  logic        fetch_valid,
  output logic [31:0] instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        pc,
  input  logic        branch,
  input  logic [31:0] data_out,
  output logic        retire
);

  // state   | meaning
  // FETCH   | request word at pc_reg, core sees NOP
  // EXEC    | core runs latched word, counter/cycle advance
  // DRAIN   | (prefetch only) finish stale request after a taken jump, discard data
`ifdef NANOV_PREFETCH_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1} state_t;
`endif

  localparam logic [31:0] PC_RST = {PC_RESET[31:2], 2'b00};
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_t      state_q, state_n;
  logic [31:0] pc_reg, pc_n;
  logic        fetch_req_n;
  logic [31:0] fetch_addr_n;
  logic [31:0] instr_n;
  logic [2:0]  cycle_n;
  logic [4:0]  counter_n;
  logic        retire_n;
  logic        branch_taken, branch_taken_n;
  logic [31:0] target, target_n;
`ifdef NANOV_PREFETCH_EN
  logic        buf_valid, buf_valid_n;
  logic [31:0] buf_data, buf_data_n;
`endif

  logic        last;
  logic        is_last;
  logic        xfer;
  logic        at_end;
  logic [31:0] pc_next;
  logic        unused_data_lsbs;

  assign last             = (instr[6:4] == 3'b110) && instr[2];
  assign is_last          = (cycle == {2'b00, last});
  assign xfer             = fetch_req && fetch_valid;
  assign at_end           = (state_q == S_EXEC) && (counter == 5'd31) && is_last;
  assign pc_next          = branch_taken ? target : pc_reg + 32'd4;
  assign pc               = pc_reg[counter];
  assign unused_data_lsbs = ^data_out[1:0];

  always_comb begin
    state_n        = state_q;
    pc_n           = pc_reg;
    fetch_req_n    = fetch_req;
    fetch_addr_n   = fetch_addr;
    instr_n        = instr;
    cycle_n        = cycle;
    counter_n      = counter;
    retire_n       = 1'b0;
    branch_taken_n = branch_taken;
    target_n       = target;
`ifdef NANOV_PREFETCH_EN
    buf_valid_n    = buf_valid;
    buf_data_n     = buf_data;
`endif
    case (state_q)
      S_FETCH: begin
        instr_n     = NOP;
        counter_n   = 5'd0;
        cycle_n     = 3'd0;
        fetch_req_n = 1'b1;
        if (xfer) begin
          state_n     = S_EXEC;
          instr_n     = fetch_data;
          fetch_req_n = 1'b0;
        end
      end
      S_EXEC: begin
        counter_n = counter + 5'd1;
        // retire is registered, so it is scheduled one clock ahead
        if (counter == 5'd30 && is_last)
          retire_n = 1'b1;
        if (counter == 5'd31 && !is_last)
          cycle_n = cycle + 3'd1;
        if (counter == 5'd31 && cycle == 3'd0 && !is_last && branch)
          branch_taken_n = 1'b1;
        if (counter == 5'd0 && cycle == 3'd1 && branch_taken)
          target_n = {data_out[31:2], 2'b00};
`ifdef NANOV_PREFETCH_EN
        if (xfer) begin
          buf_valid_n = 1'b1;
          buf_data_n  = fetch_data;
          fetch_req_n = 1'b0;
        end else if (!fetch_req && !buf_valid) begin
          fetch_req_n  = 1'b1;
          fetch_addr_n = pc_reg + 32'd4;
        end
`endif
        if (at_end) begin
          pc_n           = pc_next;
          branch_taken_n = 1'b0;
          cycle_n        = 3'd0;
          counter_n      = 5'd0;
          state_n        = S_FETCH;
          instr_n        = NOP;
          fetch_req_n    = 1'b1;
          fetch_addr_n   = pc_next;
`ifdef NANOV_PREFETCH_EN
          buf_valid_n = 1'b0;
          if (branch_taken) begin
            if (fetch_req && !fetch_valid) begin
              state_n      = S_DRAIN;
              fetch_addr_n = fetch_addr;
            end
          end else if (buf_valid || xfer) begin
            state_n     = S_EXEC;
            instr_n     = buf_valid ? buf_data : fetch_data;
            fetch_req_n = 1'b0;
          end else if (fetch_req) begin
            fetch_addr_n = fetch_addr;
          end
`endif
        end
      end
`ifdef NANOV_PREFETCH_EN
      S_DRAIN: begin
        instr_n     = NOP;
        counter_n   = 5'd0;
        cycle_n     = 3'd0;
        fetch_req_n = 1'b1;
        if (xfer) begin
          state_n      = S_FETCH;
          fetch_addr_n = pc_reg;
        end
      end
`endif
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_reg       <= PC_RST;
      fetch_req    <= 1'b0;
      fetch_addr   <= PC_RST;
      instr        <= NOP;
      cycle        <= 3'd0;
      counter      <= 5'd0;
      retire       <= 1'b0;
      branch_taken <= 1'b0;
      target       <= 32'd0;
`ifdef NANOV_PREFETCH_EN
      buf_valid    <= 1'b0;
      buf_data     <= 32'd0;
`endif
    end else begin
      state_q      <= state_n;
      pc_reg       <= pc_n;
      fetch_req    <= fetch_req_n;
      fetch_addr   <= fetch_addr_n;
      instr        <= instr_n;
      cycle        <= cycle_n;
      counter      <= counter_n;
      retire       <= retire_n;
      branch_taken <= branch_taken_n;
      target       <= target_n;
`ifdef NANOV_PREFETCH_EN
      buf_valid    <= buf_valid_n;
      buf_data     <= buf_data_n;
`endif
    end
  end

endmodule

// File: tb/tb_nanov_sequencer.sv
// Bench for nanov_sequencer: memory responder, core/branch model and scoreboard.
module tb_nanov_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef NANOV_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data = 32'd0;
  logic        fetch_valid;
  logic [31:0] instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        pc;
  logic        branch = 1'b0;
  logic [31:0] data_out = 32'hFFFF_FFF0;
  logic        retire;

  logic resp_valid = 1'b0;
  logic force_valid = 1'b0;
  assign fetch_valid = resp_valid | force_valid;

  // low address bits of PC_RESET must be dropped by the design
  nanov_sequencer #(.PC_RESET(32'h0000_0003)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .instr(instr), .cycle(cycle), .counter(counter), .pc(pc),
    .branch(branch), .data_out(data_out), .retire(retire)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] word; } fetch_t;
  typedef struct { logic [31:0] pc; int len; int t; } ret_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] word; bit taken; logic [31:0] dout; int delay; int exp_len;
  } vec_t;

  fetch_t      sb[$];
  ret_t        retq[$];
  logic [31:0] mem [64];
  int          dly [64];
  bit          tk  [64];
  logic [31:0] tgt [64];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory side: answers each request after dly[] clocks, logs delivered words
  initial begin : responder
    int wcnt;
    bit prev;
    logic [31:0] held;
    wcnt = 0;
    held = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_valid = 1'b0;
        wcnt = 0;
      end else begin
        prev = resp_valid;
        resp_valid = 1'b0;
        if (prev) wcnt = 0;
        if (fetch_req) begin
          if (wcnt == 0) held = fetch_addr;
          else chk("req_addr_stable", fetch_addr, held);
          if (wcnt >= dly[fetch_addr[7:2]]) begin
            resp_valid = 1'b1;
            fetch_data = mem[fetch_addr[7:2]];
            sb.push_back('{fetch_addr, mem[fetch_addr[7:2]]});
          end else begin
            wcnt++;
          end
        end else if (wcnt > 0) begin
          chk("req_held", {31'd0, fetch_req}, 32'd1);
          wcnt = 0;
        end
      end
    end
  end

  // core side: checks execution timing, drives branch/data_out, logs retirements
  initial begin : monitor
    fetch_t e;
    logic [31:0] cur_pc, cur_word, skip_addr;
    int n;
    bit running, skip_pending;
    running = 1'b0; skip_pending = 1'b0; n = 0;
    cur_pc = 32'd0; cur_word = 32'd0; skip_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        running = 1'b0;
        skip_pending = 1'b0;
        sb.delete();
        retq.delete();
        branch = 1'b0;
      end else if (instr == NOP) begin
        chk("idle_counter", {27'd0, counter}, 32'd0);
        chk("idle_cycle", {29'd0, cycle}, 32'd0);
        chk("idle_retire", {31'd0, retire}, 32'd0);
        chk("idle_not_mid_instr", {31'd0, running}, 32'd0);
        running = 1'b0;
        branch = 1'b0;
      end else begin
        if (!running) begin
          if (skip_pending) begin
            chk("drain_word_logged", (sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("drain_addr", e.addr, skip_addr);
            end
            skip_pending = 1'b0;
          end
          chk("fetch_logged", (sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            cur_pc = e.addr;
            cur_word = e.word;
          end
          chk("instr_word", instr, cur_word);
          running = 1'b1;
          n = 0;
        end
        chk("counter", {27'd0, counter}, n % 32);
        chk("cycle", {29'd0, cycle}, n / 32);
        chk("pc_bit", {31'd0, pc}, {31'd0, cur_pc[counter]});
        branch = (counter == 5'd31) && (cycle == 3'd0) && tk[cur_pc[7:2]];
        data_out = (cycle == 3'd1 && counter == 5'd0) ? tgt[cur_pc[7:2]] : 32'hFFFF_FFF0;
        if (retire) begin
          chk("retire_counter", {27'd0, counter}, 32'd31);
          retq.push_back('{cur_pc, n + 1, cyc});
          running = 1'b0;
          if (PREF && cur_word[6:4] == 3'b110 && cur_word[2] && tk[cur_pc[7:2]]) begin
            skip_pending = 1'b1;
            skip_addr = cur_pc + 32'd4;
          end
        end
        n++;
      end
    end
  end

  initial begin : main
    vec_t v[10];
    ret_t r;
    int k, prev_t;
    v[0] = '{32'h00, 32'h0050_0093, 1'b0, 32'h0,         0, 32};
    v[1] = '{32'h04, 32'h0010_0113, 1'b0, 32'h0,         5, 32};
    v[2] = '{32'h08, 32'h0020_0193, 1'b0, 32'h0,         0, 32};
    v[3] = '{32'h0C, 32'h0030_0213, 1'b0, 32'h0,         0, 32};
    v[4] = '{32'h10, 32'h0080_006F, 1'b1, 32'h19,        0, 64};
    v[5] = '{32'h18, 32'h0000_0067, 1'b0, 32'h0,         0, 64};
    v[6] = '{32'h1C, 32'h0000_0063, 1'b1, 32'h0000_0101, 0, 32};
    v[7] = '{32'h20, 32'h0000_006F, 1'b1, 32'h43,        0, 64};
    v[8] = '{32'h40, 32'h0040_0293, 1'b0, 32'h0,         0, 32};
    v[9] = '{32'h44, 32'h0050_0313, 1'b0, 32'h0,         0, 32};
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0000_0093 | (i << 20);
      dly[i] = 0;
      tk[i]  = 1'b0;
      tgt[i] = 32'd0;
    end
    for (int i = 0; i < 10; i++) begin
      mem[v[i].addr[7:2]] = v[i].word;
      dly[v[i].addr[7:2]] = v[i].delay;
      tk[v[i].addr[7:2]]  = v[i].taken;
      tgt[v[i].addr[7:2]] = v[i].dout;
    end
    dly[9] = 65;  // 0x24: prefetch behind the 0x20 jump completes 3 clocks after its retire

    repeat (3) @(posedge clk);
    #2;
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_fetch_addr", fetch_addr, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_cycle", {29'd0, cycle}, 32'd0);
    chk("rst_counter", {27'd0, counter}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("first_req", {31'd0, fetch_req}, 32'd1);
    chk("first_addr", fetch_addr, 32'd0);

    k = 0;
    while (retq.size() < 10 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("program_done", (retq.size() >= 10), 32'd1);
    prev_t = 0;
    for (int i = 0; i < 10; i++) begin
      if (retq.size() == 0) break;
      r = retq.pop_front();
      chk($sformatf("ret%0d_pc", i), r.pc, v[i].addr);
      chk($sformatf("ret%0d_len", i), r.len, v[i].exp_len);
      if (i == 3 || i == 9)
        chk($sformatf("ret%0d_period", i), r.t - prev_t, PREF ? 32 : 33);
      prev_t = r.t;
    end

    // reset in the middle of an instruction, with a stray valid in the reset clock
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!(instr != NOP && counter == 5'd17) && k < 300);
    chk("mid_exec_reached", {27'd0, counter}, 32'd17);
    rst = 1'b1;
    force_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    force_valid = 1'b0;
    chk("mrst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("mrst_counter", {27'd0, counter}, 32'd0);
    chk("mrst_instr", instr, NOP);
    chk("mrst_retire", {31'd0, retire}, 32'd0);
    chk("mrst_fetch_addr", fetch_addr, 32'd0);
    @(posedge clk);
    #2;
    chk("mrst_req_rise", {31'd0, fetch_req}, 32'd1);
    chk("mrst_req_addr", fetch_addr, 32'd0);
    k = 0;
    while (retq.size() == 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("mrst_retired", (retq.size() > 0), 32'd1);
    if (retq.size() > 0) begin
      r = retq.pop_front();
      chk("mrst_ret_pc", r.pc, 32'd0);
      chk("mrst_ret_len", r.len, 32);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
